// File: rtl/q2_seq_pkg.sv
// rtl/q2_seq_pkg.sv - shared types and helpers for the Q2 product sequencer
package q2_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FETCH = 3'd2,
    PROD  = 3'd3,
    ROT   = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef enum logic {
    OWN_NONSTAB = 1'b0,
    OWN_STAB    = 1'b1
  } owner_e;

  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/q2_rr_arbiter.sv
// rtl/q2_rr_arbiter.sv - two-way round-robin arbiter for Q2 ownership
module q2_rr_arbiter
  import q2_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_nonstab,
  input  logic       req_stab,
  input  logic       arb_en,
  input  logic       ptr_upd,
  output logic [1:0] winner
);

  // last_q is the requester served most recently; resetting to stab makes a tie go to nonstab
  owner_e last_q, last_d;
  owner_e served_q, served_d;

  always_comb begin
    winner   = 2'b00;
    served_d = served_q;
    last_d   = last_q;
    if (arb_en) begin
      if (req_nonstab && (!req_stab || last_q == OWN_STAB)) begin
        winner = 2'b01;
      end else if (req_stab) begin
        winner = 2'b10;
      end
    end
    if (winner[1]) begin
      served_d = OWN_STAB;
    end else if (winner[0]) begin
      served_d = OWN_NONSTAB;
    end
    // The pointer only moves once the pass actually completes
    if (ptr_upd) begin
      last_d = served_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= OWN_STAB;
      served_q <= OWN_STAB;
    end else begin
      last_q   <= last_d;
      served_q <= served_d;
    end
  end

endmodule

// File: rtl/q2_product_sequencer.sv
// rtl/q2_product_sequencer.sv - Q2 product pass sequencer: arbitration, P load, per-column product and rotate
module q2_product_sequencer
  import q2_seq_pkg::*;
#(
  parameter int num_qubit = 4,
  parameter int idx_w     = calc_idx_w(num_qubit)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_nonstab,
  input  logic             req_stab,
  input  logic             q2_ext_busy,
  input  logic             row_valid,
  output logic             grant_nonstab,
  output logic             grant_stab,
  output logic             busy,
  output logic             valid_P_beta,
  output logic             valid_P_stabilizer,
  output logic             row_req,
  output logic [idx_w-1:0] row_idx,
  output logic             ld_prodQ2_from_nonstabilizer,
  output logic             ld_prodQ2_from_stabilizer,
  output logic             rotateLeft_Q2_from_nonstabilizer,
  output logic             rotateLeft_Q2_from_stabilizer,
  output logic             done
);

  localparam logic [idx_w-1:0] LAST_COL = idx_w'(num_qubit - 1);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [idx_w-1:0] cnt_q, cnt_d;
  logic             grant_ns_q, grant_ns_d, grant_s_q, grant_s_d;
  logic             busy_q, busy_d, load_q, load_d, fetch_q, fetch_d;
  logic             prod_q, prod_d, rot_q, rot_d, done_q, done_d;
  logic             arb_en, ptr_upd;
  logic [1:0]       winner;

  q2_rr_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_nonstab(req_nonstab),
    .req_stab   (req_stab),
    .arb_en     (arb_en),
    .ptr_upd    (ptr_upd),
    .winner     (winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    arb_en  = 1'b0;
    ptr_upd = 1'b0;
    case (state_q)
      IDLE: begin
        if ((req_nonstab || req_stab) && !q2_ext_busy) begin
          arb_en  = 1'b1;
          owner_d = winner[1] ? OWN_STAB : OWN_NONSTAB;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!q2_ext_busy) begin
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (row_valid) begin
          state_d = PROD;
        end
      end
      PROD: begin
        if (!q2_ext_busy) begin
          state_d = ROT;
        end
      end
      ROT: begin
        if (!q2_ext_busy) begin
          if (cnt_q == LAST_COL) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + idx_w'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        ptr_upd = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    grant_ns_d = (state_d != IDLE) && (owner_d == OWN_NONSTAB);
    grant_s_d  = (state_d != IDLE) && (owner_d == OWN_STAB);
    busy_d     = (state_d != IDLE);
    load_d     = (state_d == LOAD);
    fetch_d    = (state_d == FETCH);
    prod_d     = (state_d == PROD);
    rot_d      = (state_d == ROT);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONSTAB;
      cnt_q      <= '0;
      grant_ns_q <= 1'b0;
      grant_s_q  <= 1'b0;
      busy_q     <= 1'b0;
      load_q     <= 1'b0;
      fetch_q    <= 1'b0;
      prod_q     <= 1'b0;
      rot_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      grant_ns_q <= grant_ns_d;
      grant_s_q  <= grant_s_d;
      busy_q     <= busy_d;
      load_q     <= load_d;
      fetch_q    <= fetch_d;
      prod_q     <= prod_d;
      rot_q      <= rot_d;
      done_q     <= done_d;
    end
  end

  // Strobes are masked in the same cycle amplitude2 claims Q2; the state holds so they re-fire afterwards
  assign grant_nonstab                    = grant_ns_q;
  assign grant_stab                       = grant_s_q;
  assign busy                             = busy_q;
  assign row_req                          = fetch_q;
  assign row_idx                          = cnt_q;
  assign done                             = done_q;
  assign valid_P_beta                     = load_q && (owner_q == OWN_NONSTAB) && !q2_ext_busy;
  assign valid_P_stabilizer               = load_q && (owner_q == OWN_STAB) && !q2_ext_busy;
  assign ld_prodQ2_from_nonstabilizer     = prod_q && (owner_q == OWN_NONSTAB) && !q2_ext_busy;
  assign ld_prodQ2_from_stabilizer        = prod_q && (owner_q == OWN_STAB) && !q2_ext_busy;
  assign rotateLeft_Q2_from_nonstabilizer = rot_q && (owner_q == OWN_NONSTAB) && !q2_ext_busy;
  assign rotateLeft_Q2_from_stabilizer    = rot_q && (owner_q == OWN_STAB) && !q2_ext_busy;

endmodule

// File: tb/tb_q2_product_sequencer.sv
// tb/tb_q2_product_sequencer.sv - self-checking bench for q2_product_sequencer
module tb_q2_product_sequencer;

  localparam int NQ = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_nonstab = 1'b0, req_stab = 1'b0, q2_ext_busy = 1'b0, row_valid = 1'b0;
  logic          grant_nonstab, grant_stab, busy, valid_P_beta, valid_P_stabilizer, row_req;
  logic [IW-1:0] row_idx;
  logic          ld_ns, ld_s, rot_ns, rot_s, done;

  q2_product_sequencer #(.num_qubit(NQ)) dut (
    .clk                             (clk),
    .rst                             (rst),
    .req_nonstab                     (req_nonstab),
    .req_stab                        (req_stab),
    .q2_ext_busy                     (q2_ext_busy),
    .row_valid                       (row_valid),
    .grant_nonstab                   (grant_nonstab),
    .grant_stab                      (grant_stab),
    .busy                            (busy),
    .valid_P_beta                    (valid_P_beta),
    .valid_P_stabilizer              (valid_P_stabilizer),
    .row_req                         (row_req),
    .row_idx                         (row_idx),
    .ld_prodQ2_from_nonstabilizer    (ld_ns),
    .ld_prodQ2_from_stabilizer       (ld_s),
    .rotateLeft_Q2_from_nonstabilizer(rot_ns),
    .rotateLeft_Q2_from_stabilizer   (rot_s),
    .done                            (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a pass is the op list [P, (fetch c, prod c, rot c) for c in 0..NQ-1, done]; m_pos indexes it, -1 = idle
  int m_pos       = -1;
  bit m_own_stab  = 1'b0;
  bit m_last_stab = 1'b1;

  // Per-test event log for literal expectations
  int          first_vp_ns, first_vp_s, first_done, fetch_cnt, idx2_cnt;
  longint      idx_pack;
  logic [63:0] prod_mask, rot_mask, gn_rise, gs_rise;
  int          stab_any;
  logic        prev_gn, prev_gs;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [10:0] dut_vec();
    return {grant_nonstab, grant_stab, busy, valid_P_beta, valid_P_stabilizer, row_req,
            ld_ns, ld_s, rot_ns, rot_s, done};
  endfunction

  function automatic int m_kind();
    if (m_pos < 0) return 0;
    if (m_pos == 0) return 1;
    if (m_pos == 3 * NQ + 1) return 5;
    return 2 + (m_pos - 1) % 3;
  endfunction

  task automatic step(input logic rn, input logic rs, input logic rv, input logic eb);
    int          k;
    bit          act, own;
    logic [10:0] exp;
    @(negedge clk);
    req_nonstab = rn;
    req_stab    = rs;
    row_valid   = rv;
    q2_ext_busy = eb;
    #1;
    k   = m_kind();
    act = (m_pos >= 0);
    own = m_own_stab;
    exp = {act && !own, act && own, act,
           k == 1 && !eb && !own, k == 1 && !eb && own, k == 2,
           k == 3 && !eb && !own, k == 3 && !eb && own,
           k == 4 && !eb && !own, k == 4 && !eb && own, k == 5};
    check("outputs", longint'(dut_vec()), longint'(exp));
    if (k == 2) check("row_idx", longint'(row_idx), longint'((m_pos - 1) / 3));
    case (k)
      0: if ((rn || rs) && !eb) begin
           m_own_stab = rs && (!rn || !m_last_stab);
           m_pos      = 0;
         end
      2: if (rv) m_pos++;
      5: begin
           m_last_stab = m_own_stab;
           m_pos       = -1;
         end
      default: if (!eb) m_pos++;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    req_nonstab = 1'b0;
    req_stab    = 1'b0;
    row_valid   = 1'b0;
    q2_ext_busy = 1'b0;
    #1;
    check("reset_outputs", longint'(dut_vec()), 0);
    m_pos       = -1;
    m_last_stab = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic log_clear();
    first_vp_ns = -1; first_vp_s = -1; first_done = -1;
    fetch_cnt = 0; idx2_cnt = 0; idx_pack = 0; stab_any = 0;
    prod_mask = '0; rot_mask = '0; gn_rise = '0; gs_rise = '0;
    prev_gn = 1'b0; prev_gs = 1'b0;
  endtask

  task automatic log_cycle(input int c);
    if (valid_P_beta && first_vp_ns < 0) first_vp_ns = c;
    if (valid_P_stabilizer && first_vp_s < 0) first_vp_s = c;
    if (done && first_done < 0) first_done = c;
    if (ld_ns || ld_s) prod_mask[c] = 1'b1;
    if (rot_ns || rot_s) rot_mask[c] = 1'b1;
    if (grant_nonstab && !prev_gn) gn_rise[c] = 1'b1;
    if (grant_stab && !prev_gs) gs_rise[c] = 1'b1;
    prev_gn = grant_nonstab;
    prev_gs = grant_stab;
    if (grant_stab || valid_P_stabilizer || ld_s || rot_s) stab_any++;
    if (row_req) begin
      if (row_idx == 2) idx2_cnt++;
      if (fetch_cnt < 16) idx_pack = idx_pack | (longint'(row_idx) << (4 * fetch_cnt));
      fetch_cnt++;
    end
  endtask

  initial begin
    logic rn, rs, rv, eb;

    // Single nonstab request, row_valid always ready
    do_reset();
    log_clear();
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      log_cycle(c);
    end
    check("t1_valid_P_cycle", first_vp_ns, 1);
    check("t1_prod_cycles", longint'(prod_mask), (1 << 3) | (1 << 6) | (1 << 9) | (1 << 12));
    check("t1_rot_cycles", longint'(rot_mask), (1 << 4) | (1 << 7) | (1 << 10) | (1 << 13));
    check("t1_done_cycle", first_done, 14);
    check("t1_row_idx_seq", idx_pack, 64'h3210);
    check("t1_fetch_cycles", fetch_cnt, 4);
    check("t1_stab_quiet", stab_any, 0);

    // Both request together; alternation nonstab, stab, nonstab
    do_reset();
    log_clear();
    for (int c = 0; c < 34; c++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      log_cycle(c);
    end
    check("t2_nonstab_grants", longint'(gn_rise), (longint'(1) << 1) | (longint'(1) << 31));
    check("t2_stab_grant", longint'(gs_rise), longint'(1) << 16);

    // row_valid withheld for three cycles in column 2
    do_reset();
    log_clear();
    for (int c = 0; c < 19; c++) begin
      step(1'b1, 1'b0, !(c >= 8 && c <= 10), 1'b0);
      log_cycle(c);
    end
    check("t3_idx2_hold", idx2_cnt, 4);
    check("t3_prod_cycles", longint'(prod_mask), (1 << 3) | (1 << 6) | (1 << 12) | (1 << 15));
    check("t3_pass_len", first_done - first_vp_ns + 1, 17);

    // amplitude2 owns Q2 while stab requests from IDLE
    do_reset();
    log_clear();
    for (int c = 0; c < 7; c++) begin
      step(1'b0, 1'b1, 1'b1, c < 3);
      log_cycle(c);
    end
    check("t4_grant_after_busy", longint'(gs_rise), longint'(1) << 4);
    check("t4_load_cycle", first_vp_s, 4);

    // amplitude2 stall during ROT of column 1
    do_reset();
    log_clear();
    for (int c = 0; c < 18; c++) begin
      step(1'b1, 1'b0, 1'b1, c == 7 || c == 8);
      log_cycle(c);
    end
    check("t5_rot_cycles", longint'(rot_mask), (1 << 4) | (1 << 9) | (1 << 12) | (1 << 15));
    check("t5_row_idx_seq", idx_pack, 64'h3210);
    check("t5_done_cycle", first_done, 16);

    // Reset while fetching column 2, then a fresh pass
    do_reset();
    log_clear();
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b0, c < 8, 1'b0);
      log_cycle(c);
    end
    check("t6_pre_reset_idx", longint'(row_idx), 2);
    do_reset();
    log_clear();
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      log_cycle(c);
    end
    check("t6_restart_load", first_vp_ns, 1);
    check("t6_restart_idx", idx_pack, 0);
    check("t6_restart_fetch", fetch_cnt, 1);

    // Randomized traffic against the model
    rn = 1'b0;
    rs = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) rn = ~rn;
      if ($urandom_range(0, 7) == 0) rs = ~rs;
      rv = ($urandom_range(0, 2) != 0);
      eb = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(rn, rs, rv, eb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
